// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: access sizes, FSM states, store lane helpers.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package mem_pkg;

    // Access size encodings as carried by exm_size (2'b11 behaves as a word)
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // Memory-side controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2,
        ST_DBG  = 2'd3
    } state_t;

    // Byte-enable patterns
    localparam logic [3:0] BE_ALL  = 4'b1111;
    localparam logic [3:0] BE_B0   = 4'b0001;
    localparam logic [3:0] BE_H_LO = 4'b0011;
    localparam logic [3:0] BE_H_HI = 4'b1100;

    // Both 2'b10 and 2'b11 are word accesses
    function automatic logic is_word(input logic [1:0] sz);
        return sz[1];
    endfunction

    function automatic logic is_half(input logic [1:0] sz);
        return sz == SZ_H;
    endfunction

    // Byte enables for a store of the given size at byte offset a
    function automatic logic [3:0] store_be(input logic [1:0] sz, input logic [1:0] a);
        logic [3:0] be;
        if (is_word(sz)) begin
            be = BE_ALL;
        end else if (is_half(sz)) begin
            be = a[1] ? BE_H_HI : BE_H_LO;
        end else begin
            be = BE_B0 << a;
        end
        return be;
    endfunction

    // Store data replicated across lanes so the memory only needs byte enables
    function automatic logic [31:0] store_wdata(input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] w;
        if (is_word(sz)) begin
            w = d;
        end else if (is_half(sz)) begin
            w = {2{d[15:0]}};
        end else begin
            w = {4{d[7:0]}};
        end
        return w;
    endfunction

endpackage

// File: rtl/mem_stage_ctrl_load_align.sv
// Load lane select and sign/zero extension of a little-endian memory word.
// Latency: combinational.
// Backpressure: none; output follows inputs.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] load_data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Pick the addressed lane, then widen it according to size and signedness
    always_comb begin
        byte_lane = 8'h00;
        half_lane = 16'h0000;
        load_data = 32'h0000_0000;
        case (addr_lo)
            2'd0:    byte_lane = rdata[7:0];
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            default: byte_lane = rdata[31:24];
        endcase
        half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        if (is_word(size)) begin
            load_data = rdata;
        end else if (is_half(size)) begin
            load_data = {{16{half_lane[15] & ~is_unsigned}}, half_lane};
        end else begin
            load_data = {{24{byte_lane[7] & ~is_unsigned}}, byte_lane};
        end
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage: branch resolve/flush, load/store to variable-latency memory, idle-time debug word reads.
// Latency: a load stalls >= 2 cycles (issue cycle + wait cycles until mem_ready); result valid in DONE.
// Backpressure: mem_req held until mem_ready or MAX_WAIT timeout; mem_stall freezes upstream meanwhile.
module mem_stage_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int MAX_WAIT = 255,
    parameter int DBG_EN   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              exm_valid,
    input  logic              exm_memread,
    input  logic              exm_memwrite,
    input  logic [1:0]        exm_size,
    input  logic              exm_unsigned,
    input  logic [31:0]       exm_aluresult,
    input  logic [31:0]       exm_wdata,
    input  logic              exm_branch,
    input  logic              exm_cond,
    input  logic              stall,
    input  logic              dbg_rd,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    output logic [31:0]       load_data,
    output logic              pcsrc,
    output logic              flush,
    output logic              mem_stall,
    output logic              misalign_exc,
    output logic              mem_err,
    output logic [31:0]       dbg_data,
    output logic              dbg_valid
);

    localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = (MAX_WAIT > 0) ? CNT_W'(MAX_WAIT - 1) : '0;

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              dbg_valid_q, dbg_valid_d;
    logic [31:0]       dbg_data_q, dbg_data_d;
    logic [31:0]       load_data_q, load_data_d;

    logic              mem_op;
    logic              acc;
    logic              dbg_go;
    logic              timeout;
    logic [31:0]       aligned;
    logic              unused_addr_hi;

    // Address bits beyond the memory's reach are intentionally dropped
    assign unused_addr_hi = ^exm_aluresult[31:ADDR_W+2];

    load_align u_load_align (
        .rdata       (mem_rdata),
        .addr_lo     (exm_aluresult[1:0]),
        .size        (exm_size),
        .is_unsigned (exm_unsigned),
        .load_data   (aligned)
    );

    // Instruction decode: misalignment, legal access, branch outcome and stall/flush
    always_comb begin
        mem_op       = exm_valid & (exm_memread | exm_memwrite);
        misalign_exc = mem_op & ((is_word(exm_size) & (exm_aluresult[1:0] != 2'b00)) |
                                 (is_half(exm_size) & exm_aluresult[0]));
        acc          = mem_op & ~misalign_exc;
        dbg_go       = (DBG_EN != 0) & dbg_rd;
        timeout      = (MAX_WAIT != 0) & (cnt_q == CNT_LAST);
        pcsrc        = exm_valid & exm_branch & exm_cond;
        mem_stall    = ((state_q == ST_IDLE) & acc) | (state_q == ST_WAIT) |
                       ((state_q == ST_DBG) & acc);
        flush        = pcsrc & ~stall & ~mem_stall;
    end

    // Next-state and request/result bookkeeping for the memory handshake
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        err_d       = 1'b0;
        dbg_valid_d = 1'b0;
        dbg_data_d  = dbg_data_q;
        load_data_d = load_data_q;
        case (state_q)
            ST_IDLE: begin
                // Pipeline access takes priority over a pending debug read
                if (acc) begin
                    state_d = ST_WAIT;
                    req_d   = 1'b1;
                    we_d    = exm_memwrite;
                    addr_d  = exm_aluresult[ADDR_W+1:2];
                    be_d    = exm_memwrite ? store_be(exm_size, exm_aluresult[1:0]) : BE_ALL;
                    wdata_d = exm_memwrite ? store_wdata(exm_size, exm_wdata) : 32'h0;
                    cnt_d   = '0;
                end else if (dbg_go) begin
                    state_d = ST_DBG;
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                    addr_d  = dbg_addr;
                    be_d    = BE_ALL;
                    wdata_d = 32'h0;
                    cnt_d   = '0;
                end
            end
            ST_WAIT: begin
                if (mem_ready) begin
                    state_d = ST_DONE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    if (!we_q) begin
                        load_data_d = aligned;
                    end
                end else if (timeout) begin
                    state_d     = ST_DONE;
                    req_d       = 1'b0;
                    we_d        = 1'b0;
                    err_d       = 1'b1;
                    load_data_d = 32'h0;
                end else if (cnt_q != CNT_SAT) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                // Hold here while the hazard unit freezes us so the access is not re-issued
                if (!stall) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DBG: begin
                if (mem_ready) begin
                    state_d     = ST_IDLE;
                    req_d       = 1'b0;
                    dbg_data_d  = mem_rdata;
                    dbg_valid_d = 1'b1;
                end else if (timeout) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                end else if (cnt_q != CNT_SAT) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
                we_d    = 1'b0;
            end
        endcase
    end

    // State registers; reset abandons any outstanding request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            be_q        <= BE_ALL;
            wdata_q     <= 32'h0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            dbg_valid_q <= 1'b0;
            dbg_data_q  <= 32'h0;
            load_data_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            dbg_valid_q <= dbg_valid_d;
            dbg_data_q  <= dbg_data_d;
            load_data_q <= load_data_d;
        end
    end

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;
    assign mem_err   = err_q;
    assign load_data = load_data_q;
    assign dbg_data  = dbg_data_q;
    assign dbg_valid = (DBG_EN != 0) & dbg_valid_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: loads/stores, misalignment, branches, debug reads, timeout, reset.
// Latency: drives on the falling edge, samples 1 time unit later.
// Backpressure: memory model raises mem_ready after a per-access number of request cycles.
module tb_mem_stage_ctrl;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        exm_valid, exm_memread, exm_memwrite, exm_unsigned, exm_branch, exm_cond;
    logic [1:0]  exm_size;
    logic [31:0] exm_aluresult, exm_wdata;
    logic        stall, dbg_rd, mem_ready;
    logic [7:0]  dbg_addr;
    logic [31:0] mem_rdata;
    logic        mem_req, mem_we, pcsrc, flush, mem_stall, misalign_exc, mem_err, dbg_valid;
    logic [7:0]  mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata, load_data, dbg_data;

    int checks = 0;
    int errors = 0;

    int          st, rq;
    logic        swe, tmo;
    logic [7:0]  sad;
    logic [3:0]  sbe;
    logic [31:0] swd;

    mem_stage_ctrl #(.ADDR_W(8), .MAX_WAIT(4), .DBG_EN(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .exm_valid(exm_valid), .exm_memread(exm_memread), .exm_memwrite(exm_memwrite),
        .exm_size(exm_size), .exm_unsigned(exm_unsigned), .exm_aluresult(exm_aluresult),
        .exm_wdata(exm_wdata), .exm_branch(exm_branch), .exm_cond(exm_cond),
        .stall(stall), .dbg_rd(dbg_rd), .dbg_addr(dbg_addr),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .load_data(load_data), .pcsrc(pcsrc), .flush(flush),
        .mem_stall(mem_stall), .misalign_exc(misalign_exc), .mem_err(mem_err),
        .dbg_data(dbg_data), .dbg_valid(dbg_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1, "watchdog");
    end

    task automatic clear_exm();
        exm_valid = 0; exm_memread = 0; exm_memwrite = 0; exm_size = SZ_W; exm_unsigned = 0;
        exm_aluresult = 0; exm_wdata = 0; exm_branch = 0; exm_cond = 0;
    endtask

    // Issues one access and plays the memory; ready comes in request cycle rdy_after (0 = never)
    task automatic access(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd, input int rdy_after,
                          input logic [31:0] rword, output int stalls, output int reqs,
                          output logic s_we, output logic [7:0] s_addr, output logic [3:0] s_be,
                          output logic [31:0] s_wd, output logic to);
        @(negedge clk);
        exm_valid = 1; exm_memread = rd; exm_memwrite = wr; exm_size = sz; exm_unsigned = uns;
        exm_aluresult = a; exm_wdata = wd; mem_ready = 0;
        stalls = 0; reqs = 0; to = 1; s_we = 0; s_addr = 0; s_be = 0; s_wd = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (!mem_stall) begin
                to = 0;
                break;
            end
            stalls++;
            if (mem_req) begin
                if (reqs == 0) begin
                    s_we = mem_we; s_addr = mem_addr; s_be = mem_be; s_wd = mem_wdata;
                end
                if (reqs == rdy_after - 1) begin
                    mem_ready = 1; mem_rdata = rword;
                end
                reqs++;
            end
            @(negedge clk);
            mem_ready = 0;
        end
    endtask

    task automatic finish_instr();
        @(negedge clk);
        clear_exm();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 0; clear_exm(); stall = 0; dbg_rd = 0; dbg_addr = 0; mem_ready = 0; mem_rdata = 0;
        #12;
        checks++;
        if ({mem_req, mem_we, mem_stall, mem_err, dbg_valid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, expected 00000", {mem_req, mem_we, mem_stall, mem_err, dbg_valid});
        end
        checks++;
        if ({load_data, dbg_data} !== 64'h0) begin
            errors++;
            $display("FAIL reset_data: got %h %h, expected 0 0", load_data, dbg_data);
        end
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_lw();
        access(1, 0, SZ_W, 0, 32'h10, 0, 3, 32'hDEADBEEF, st, rq, swe, sad, sbe, swd, tmo);
        checks++;
        if (tmo !== 0 || st !== 4) begin
            errors++;
            $display("FAIL lw_stall: got %0d cycles (to=%b), expected 4", st, tmo);
        end
        checks++;
        if (sad !== 8'd4 || swe !== 0 || sbe !== 4'b1111) begin
            errors++;
            $display("FAIL lw_req: got addr %h we %b be %b, expected 04 0 1111", sad, swe, sbe);
        end
        checks++;
        if (load_data !== 32'hDEADBEEF || mem_req !== 0) begin
            errors++;
            $display("FAIL lw_data: got %h req %b, expected deadbeef 0", load_data, mem_req);
        end
        finish_instr();
        // Fastest case: ready in the first wait cycle
        access(1, 0, SZ_W, 0, 32'h24, 0, 1, 32'h01234567, st, rq, swe, sad, sbe, swd, tmo);
        checks++;
        if (st !== 2 || load_data !== 32'h01234567 || sad !== 8'h09) begin
            errors++;
            $display("FAIL lw_min: got %0d cycles data %h addr %h, expected 2 01234567 09", st, load_data, sad);
        end
        finish_instr();
    endtask

    task automatic test_store();
        access(0, 1, SZ_B, 0, 32'h13, 32'h000000A5, 1, 0, st, rq, swe, sad, sbe, swd, tmo);
        checks++;
        if (swe !== 1 || sbe !== 4'b1000 || swd !== 32'hA5A5A5A5 || sad !== 8'd4 || st !== 2) begin
            errors++;
            $display("FAIL sb: got we %b be %b wd %h addr %h st %0d, expected 1 1000 a5a5a5a5 04 2",
                     swe, sbe, swd, sad, st);
        end
        finish_instr();
        access(0, 1, SZ_H, 0, 32'h12, 32'h1234BEEF, 2, 0, st, rq, swe, sad, sbe, swd, tmo);
        checks++;
        if (swe !== 1 || sbe !== 4'b1100 || swd !== 32'hBEEFBEEF || st !== 3) begin
            errors++;
            $display("FAIL sh: got we %b be %b wd %h st %0d, expected 1 1100 beefbeef 3", swe, sbe, swd, st);
        end
        finish_instr();
        access(0, 1, SZ_W, 0, 32'h08, 32'hCAFE0001, 1, 0, st, rq, swe, sad, sbe, swd, tmo);
        checks++;
        if (sbe !== 4'b1111 || swd !== 32'hCAFE0001 || sad !== 8'd2) begin
            errors++;
            $display("FAIL sw: got be %b wd %h addr %h, expected 1111 cafe0001 02", sbe, swd, sad);
        end
        finish_instr();
    endtask

    task automatic test_load_align();
        logic [31:0] ta [5] = '{32'h13, 32'h13, 32'h12, 32'h10, 32'h01};
        logic [1:0]  ts [5] = '{SZ_B, SZ_B, SZ_H, SZ_H, SZ_B};
        logic        tu [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] tr [5] = '{32'hA5123456, 32'hA5123456, 32'h80017FFF, 32'h80017FFF, 32'h00007F00};
        logic [31:0] te [5] = '{32'hFFFFFFA5, 32'h000000A5, 32'hFFFF8001, 32'h00007FFF, 32'h0000007F};
        for (int i = 0; i < 5; i++) begin
            access(1, 0, ts[i], tu[i], ta[i], 0, 1, tr[i], st, rq, swe, sad, sbe, swd, tmo);
            checks++;
            if (load_data !== te[i]) begin
                errors++;
                $display("FAIL load_align[%0d]: got %h, expected %h", i, load_data, te[i]);
            end
            finish_instr();
        end
    endtask

    task automatic test_misalign();
        logic [31:0] ma [3] = '{32'h11, 32'h12, 32'h02};
        logic [1:0]  ms [3] = '{SZ_H, SZ_W, SZ_W};
        logic        mw [3] = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            exm_valid = 1; exm_memread = ~mw[i]; exm_memwrite = mw[i];
            exm_size = ms[i]; exm_aluresult = ma[i];
            #1;
            checks++;
            if (misalign_exc !== 1 || mem_stall !== 0) begin
                errors++;
                $display("FAIL misalign[%0d]: got exc %b stall %b, expected 1 0", i, misalign_exc, mem_stall);
            end
            @(negedge clk);
            #1;
            checks++;
            if (mem_req !== 0) begin
                errors++;
                $display("FAIL misalign_req[%0d]: got %b, expected 0", i, mem_req);
            end
            clear_exm();
        end
        #1;
        checks++;
        if (misalign_exc !== 0) begin
            errors++;
            $display("FAIL misalign_clear: got %b, expected 0", misalign_exc);
        end
    endtask

    task automatic test_branch();
        @(negedge clk);
        exm_valid = 1; exm_branch = 1; exm_cond = 1; stall = 0;
        #1;
        checks++;
        if (pcsrc !== 1 || flush !== 1) begin
            errors++;
            $display("FAIL br_taken: got pcsrc %b flush %b, expected 1 1", pcsrc, flush);
        end
        stall = 1;
        #1;
        checks++;
        if (pcsrc !== 1 || flush !== 0) begin
            errors++;
            $display("FAIL br_stalled: got pcsrc %b flush %b, expected 1 0", pcsrc, flush);
        end
        stall = 0; exm_cond = 0;
        #1;
        checks++;
        if (pcsrc !== 0 || flush !== 0) begin
            errors++;
            $display("FAIL br_not_taken: got pcsrc %b flush %b, expected 0 0", pcsrc, flush);
        end
        clear_exm();
    endtask

    task automatic test_debug();
        @(negedge clk);
        dbg_rd = 1; dbg_addr = 8'h20;
        @(negedge clk);
        // In DBG now; a load arrives and must wait
        dbg_rd = 0;
        exm_valid = 1; exm_memread = 1; exm_size = SZ_W; exm_aluresult = 32'h40;
        #1;
        checks++;
        if (mem_req !== 1 || mem_we !== 0 || mem_addr !== 8'h20 || mem_stall !== 1) begin
            errors++;
            $display("FAIL dbg_req: got req %b we %b addr %h stall %b, expected 1 0 20 1",
                     mem_req, mem_we, mem_addr, mem_stall);
        end
        mem_ready = 1; mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        mem_ready = 0;
        #1;
        checks++;
        if (dbg_valid !== 1 || dbg_data !== 32'hCAFEF00D || mem_req !== 0 || mem_stall !== 1) begin
            errors++;
            $display("FAIL dbg_done: got valid %b data %h req %b stall %b, expected 1 cafef00d 0 1",
                     dbg_valid, dbg_data, mem_req, mem_stall);
        end
        @(negedge clk);
        #1;
        checks++;
        if (dbg_valid !== 0 || mem_req !== 1 || mem_addr !== 8'h10) begin
            errors++;
            $display("FAIL dbg_then_lw: got valid %b req %b addr %h, expected 0 1 10", dbg_valid, mem_req, mem_addr);
        end
        mem_ready = 1; mem_rdata = 32'h11223344;
        @(negedge clk);
        mem_ready = 0;
        #1;
        checks++;
        if (mem_stall !== 0 || load_data !== 32'h11223344) begin
            errors++;
            $display("FAIL dbg_lw_data: got stall %b data %h, expected 0 11223344", mem_stall, load_data);
        end
        clear_exm();
        // Coincident debug read and load: the load goes first
        @(negedge clk);
        dbg_rd = 1; dbg_addr = 8'h33;
        exm_valid = 1; exm_memread = 1; exm_size = SZ_W; exm_aluresult = 32'h80;
        @(negedge clk);
        #1;
        checks++;
        if (mem_req !== 1 || mem_addr !== 8'h20 || mem_stall !== 1) begin
            errors++;
            $display("FAIL dbg_priority: got req %b addr %h stall %b, expected 1 20 1", mem_req, mem_addr, mem_stall);
        end
        mem_ready = 1; mem_rdata = 32'h55667788;
        @(negedge clk);
        mem_ready = 0;
        clear_exm();
        dbg_rd = 0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        access(1, 0, SZ_W, 0, 32'h30, 0, 0, 0, st, rq, swe, sad, sbe, swd, tmo);
        checks++;
        if (tmo !== 0 || rq !== 4 || st !== 5) begin
            errors++;
            $display("FAIL timeout_len: got req %0d stall %0d to %b, expected 4 5 0", rq, st, tmo);
        end
        checks++;
        if (mem_err !== 1 || mem_req !== 0 || load_data !== 32'h0) begin
            errors++;
            $display("FAIL timeout_err: got err %b req %b data %h, expected 1 0 00000000", mem_err, mem_req, load_data);
        end
        @(negedge clk);
        clear_exm();
        #1;
        checks++;
        if (mem_err !== 0) begin
            errors++;
            $display("FAIL timeout_pulse: got %b, expected 0", mem_err);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_access();
        @(negedge clk);
        exm_valid = 1; exm_memwrite = 1; exm_size = SZ_W; exm_aluresult = 32'h20; exm_wdata = 32'h1;
        @(negedge clk);
        #1;
        checks++;
        if (mem_req !== 1 || mem_we !== 1) begin
            errors++;
            $display("FAIL rst_pre: got req %b we %b, expected 1 1", mem_req, mem_we);
        end
        rst_n = 0;
        #1;
        checks++;
        if (mem_req !== 0 || mem_we !== 0) begin
            errors++;
            $display("FAIL rst_async: got req %b we %b, expected 0 0", mem_req, mem_we);
        end
        clear_exm();
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_lw();
        test_store();
        test_load_align();
        test_misalign();
        test_branch();
        test_debug();
        test_timeout();
        test_reset_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
